// File: rtl/color_pkg.sv
// Shared definitions for the colour stabiliser: colour codes, channel
// indices and the 2-bit colour type.
package color_pkg;

  typedef logic [1:0] color_t;

  localparam color_t COLOR_NONE  = 2'd0;
  localparam color_t COLOR_RED   = 2'd1;
  localparam color_t COLOR_GREEN = 2'd2;
  localparam color_t COLOR_BLUE  = 2'd3;

  localparam logic CH_OBJECT  = 1'b0;
  localparam logic CH_STATION = 1'b1;

endpackage

// File: rtl/color_debounce_ch.sv
// Per-channel colour debounce filter. On each sample tick the raw code is
// compared against a candidate; a candidate that repeats for the required
// number of consecutive ticks becomes the stable colour.
// Optional feature macro: COLOR_STABILIZER_HOLD_EN (dropping to NONE from a
// real colour then needs HOLD_COUNT samples instead of CONFIRM_COUNT).
module color_debounce_ch
  import color_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3,
  parameter int HOLD_COUNT    = 8
) (
  input  logic   clkus_i,
  input  logic   rst_i,
  input  logic   tick_i,
  input  color_t sample_i,
  output color_t stable_o,
  output logic   valid_o,
  output logic   change_o,
  output color_t change_color_o
);

  localparam logic HOLD_EN =
`ifdef COLOR_STABILIZER_HOLD_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [3:0] CONFIRM_RUN = 4'(CONFIRM_COUNT);
  localparam logic [3:0] HOLD_RUN    = 4'(HOLD_COUNT);

  color_t     cand_q, cand_d;
  logic [3:0] run_q, run_d;
  color_t     stable_q, stable_d;
  logic       valid_q, valid_d;
  logic [3:0] need_run;
  logic       change;

  // Candidate/run update and accept decision, evaluated only on a tick.
  always_comb begin
    cand_d   = cand_q;
    run_d    = run_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    need_run = CONFIRM_RUN;
    change   = 1'b0;
    if (tick_i) begin
      if (sample_i == cand_q) begin
        if (run_q != 4'hF) begin
          run_d = run_q + 4'd1;
        end
      end else begin
        cand_d = sample_i;
        run_d  = 4'd1;
      end
      // Dropouts to NONE from a real colour wait longer when hold is built in.
      if (HOLD_EN && (cand_d == COLOR_NONE) && (stable_q != COLOR_NONE)) begin
        need_run = HOLD_RUN;
      end
      if ((run_d == need_run) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        valid_d  = 1'b1;
        change   = 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clkus_i) begin
    if (rst_i) begin
      cand_q   <= COLOR_NONE;
      run_q    <= 4'd0;
      stable_q <= COLOR_NONE;
      valid_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      run_q    <= run_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
    end
  end

  // The strobe and its colour are combinational so the pending slot is
  // loaded on the same edge that updates the stable colour.
  assign stable_o       = stable_q;
  assign valid_o        = valid_q;
  assign change_o       = change;
  assign change_color_o = cand_d;

endmodule

// File: rtl/color_stabilizer.sv
// Colour stabiliser: periodic sampling of the object and station colour
// codes, per-channel debounce, and a one-slot-per-channel change event queue
// handed to Core through a valid/ack handshake (object has priority).
// Optional feature macro: COLOR_STABILIZER_HOLD_EN.
module color_stabilizer
  import color_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 8000,
  parameter int CONFIRM_COUNT = 3,
  parameter int HOLD_COUNT    = 8
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic [1:0] object_color_in,
  input  logic [1:0] station_color_in,
  output logic [1:0] object_color,
  output logic [1:0] station_color,
  output logic       object_valid,
  output logic       station_valid,
  output logic       evt_valid,
  output logic       evt_channel,
  output logic [1:0] evt_color,
  input  logic       evt_ack,
  output logic       evt_overrun
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  color_t raw          [2];
  color_t stable       [2];
  color_t change_color [2];
  color_t pcol_vec     [2];
  logic [1:0] valid_vec;
  logic [1:0] change_vec;
  logic [1:0] pend_vec;
  logic [1:0] ovr_hit;

  logic evt_valid_q, evt_valid_d;
  logic sel_q, sel_d;
  logic ovr_q, ovr_d;
  logic ack_fire;

  // Sample counter wraps at SAMPLE_PERIOD-1; the tick marks the last count.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Sample counter register.
  always_ff @(posedge clkus) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign raw[CH_OBJECT]  = object_color_in;
  assign raw[CH_STATION] = station_color_in;
  assign ack_fire        = evt_valid_q & evt_ack;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      color_t pcol_q, pcol_d;
      logic   pend_q, pend_d;
      logic   clr;
      logic   hit;

      color_debounce_ch #(
        .CONFIRM_COUNT(CONFIRM_COUNT),
        .HOLD_COUNT   (HOLD_COUNT)
      ) u_debounce (
        .clkus_i       (clkus),
        .rst_i         (rst),
        .tick_i        (tick),
        .sample_i      (raw[gi]),
        .stable_o      (stable[gi]),
        .valid_o       (valid_vec[gi]),
        .change_o      (change_vec[gi]),
        .change_color_o(change_color[gi])
      );

      // Pending slot: latest change wins; an unacked overwrite flags overrun.
      always_comb begin
        clr    = ack_fire && (sel_q == 1'(gi));
        pend_d = pend_q;
        pcol_d = pcol_q;
        hit    = 1'b0;
        if (change_vec[gi]) begin
          pend_d = 1'b1;
          pcol_d = change_color[gi];
          hit    = pend_q && !clr;
        end else if (clr) begin
          pend_d = 1'b0;
        end
      end

      // Pending slot registers.
      always_ff @(posedge clkus) begin
        if (rst) begin
          pend_q <= 1'b0;
          pcol_q <= COLOR_NONE;
        end else begin
          pend_q <= pend_d;
          pcol_q <= pcol_d;
        end
      end

      assign pend_vec[gi] = pend_q;
      assign pcol_vec[gi] = pcol_q;
      assign ovr_hit[gi]  = hit;
    end
  endgenerate

  // Arbiter: latch a selection when idle, hold it until acknowledged.
  always_comb begin
    evt_valid_d = evt_valid_q;
    sel_d       = sel_q;
    ovr_d       = ovr_q | (|ovr_hit);
    if (evt_valid_q) begin
      if (evt_ack) begin
        evt_valid_d = 1'b0;
      end
    end else if (|pend_vec) begin
      evt_valid_d = 1'b1;
      sel_d       = pend_vec[CH_OBJECT] ? CH_OBJECT : CH_STATION;
    end
  end

  // Handshake, selection and sticky overrun registers.
  always_ff @(posedge clkus) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      sel_q       <= sel_d;
      ovr_q       <= ovr_d;
    end
  end

  assign object_color  = stable[CH_OBJECT];
  assign station_color = stable[CH_STATION];
  assign object_valid  = valid_vec[CH_OBJECT];
  assign station_valid = valid_vec[CH_STATION];
  assign evt_valid     = evt_valid_q;
  assign evt_channel   = sel_q;
  assign evt_color     = evt_valid_q ? pcol_vec[sel_q] : COLOR_NONE;
  assign evt_overrun   = ovr_q;

endmodule

// File: tb/tb_color_stabilizer.sv
// Self-checking bench for color_stabilizer with a short sample period.
// Expected events are queued as stimulus is applied and compared when Core
// would see them.
module tb_color_stabilizer;

  localparam int SP = 4;
  localparam int CC = 3;
  localparam int HC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] obj_in;
  logic [1:0] sta_in;
  logic [1:0] object_color;
  logic [1:0] station_color;
  logic       object_valid;
  logic       station_valid;
  logic       evt_valid;
  logic       evt_channel;
  logic [1:0] evt_color;
  logic       evt_ack;
  logic       evt_overrun;

  typedef struct {
    logic       ch;
    logic [1:0] col;
  } evt_t;

  evt_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  always #5 clk = ~clk;

  color_stabilizer #(
    .SAMPLE_PERIOD(SP),
    .CONFIRM_COUNT(CC),
    .HOLD_COUNT   (HC)
  ) dut (
    .clkus           (clk),
    .rst             (rst),
    .object_color_in (obj_in),
    .station_color_in(sta_in),
    .object_color    (object_color),
    .station_color   (station_color),
    .object_valid    (object_valid),
    .station_valid   (station_valid),
    .evt_valid       (evt_valid),
    .evt_channel     (evt_channel),
    .evt_color       (evt_color),
    .evt_ack         (evt_ack),
    .evt_overrun     (evt_overrun)
  );

  // One clock; phase tracks the expected sample counter value.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) phase = 0;
    else     phase = (phase + 1) % SP;
  endtask

  // Advance to just after the next tick edge.
  task automatic to_tick();
    int was;
    for (int i = 0; i < SP + 1; i++) begin
      was = phase;
      step();
      if (was == SP - 1) break;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    evt_ack = 1'b0;
    obj_in  = 2'd0;
    sta_in  = 2'd0;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  // Wait for an event, compare it with the scoreboard head, then ack it.
  task automatic handle_event(input int max_wait, output int waited);
    evt_t exp;
    waited = 0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected event queued");
      return;
    end
    exp = sb.pop_front();
    while (!evt_valid && waited < max_wait) begin
      step();
      waited++;
    end
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL evt_timeout: evt_valid=%b required 1 within %0d cycles", evt_valid, max_wait);
      return;
    end
    $display("event ch=%0d color=%0d (exp ch=%0d color=%0d)", evt_channel, evt_color, exp.ch, exp.col);
    checks++;
    if (evt_channel !== exp.ch) begin
      errors++;
      $display("FAIL evt_channel: got %b required %b", evt_channel, exp.ch);
    end
    checks++;
    if (evt_color !== exp.col) begin
      errors++;
      $display("FAIL evt_color: got %0d required %0d", evt_color, exp.col);
    end
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL evt_drop_after_ack: got %b required 0", evt_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({object_color, station_color, object_valid, station_valid, evt_valid,
         evt_channel, evt_color, evt_overrun} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {object_color, station_color,
               object_valid, station_valid, evt_valid, evt_channel, evt_color, evt_overrun});
    end
    // Ack with nothing presented is ignored.
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    step();
    checks++;
    if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: valid=%b overrun=%b required 0 0", evt_valid, evt_overrun);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int w;
    do_reset();
    obj_in = 2'd2;
    to_tick();
    to_tick();
    checks++;
    if (object_color !== 2'd0 || object_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: color=%0d valid=%b required 0 0", object_color, object_valid);
    end
    to_tick();
    checks++;
    if (object_color !== 2'd2 || object_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: color=%0d valid=%b required 2 1", object_color, object_valid);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_evt_latency: evt_valid=%b required 0 at accept edge", evt_valid);
    end
    sb.push_back('{ch: 1'b0, col: 2'd2});
    handle_event(4, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL basic_evt_wait: got %0d required 1", w);
    end
  endtask

  task automatic test_flicker();
    logic [1:0] seq [5];
    int w;
    seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd1; seq[4] = 2'd1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      obj_in = seq[i];
      to_tick();
    end
    checks++;
    if (object_color !== 2'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flicker_reject: color=%0d evt_valid=%b required 0 0", object_color, evt_valid);
    end
    to_tick();
    checks++;
    if (object_color !== 2'd1) begin
      errors++;
      $display("FAIL flicker_accept: color=%0d required 1", object_color);
    end
    sb.push_back('{ch: 1'b0, col: 2'd1});
    handle_event(4, w);
  endtask

  task automatic test_simultaneous();
    int w;
    do_reset();
    obj_in = 2'd3;
    sta_in = 2'd3;
    repeat (3) to_tick();
    checks++;
    if (object_color !== 2'd3 || station_color !== 2'd3 || station_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_accept: obj=%0d sta=%0d sval=%b required 3 3 1",
               object_color, station_color, station_valid);
    end
    sb.push_back('{ch: 1'b0, col: 2'd3});
    sb.push_back('{ch: 1'b1, col: 2'd3});
    handle_event(4, w);
    handle_event(4, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL simul_idle_gap: waited %0d required 1", w);
    end
  endtask

  task automatic test_overrun();
    int w;
    do_reset();
    obj_in = 2'd1;
    repeat (3) to_tick();
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_color !== 2'd1 || evt_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: valid=%b color=%0d ovr=%b required 1 1 0",
               evt_valid, evt_color, evt_overrun);
    end
    obj_in = 2'd2;
    repeat (3) begin
      to_tick();
      checks++;
      if (evt_channel !== 1'b0) begin
        errors++;
        $display("FAIL overrun_channel: got %b required 0", evt_channel);
      end
    end
    checks++;
    if (evt_color !== 2'd2 || evt_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_replace: color=%0d ovr=%b required 2 1", evt_color, evt_overrun);
    end
    sb.push_back('{ch: 1'b0, col: 2'd2});
    handle_event(2, w);
    step();
    checks++;
    if (evt_overrun !== 1'b1 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%b valid=%b required 1 0", evt_overrun, evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    obj_in = 2'd1;
    repeat (3) to_tick();
    step();
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: evt_valid=%b required 1", evt_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({object_color, station_color, object_valid, station_valid, evt_valid,
         evt_channel, evt_color, evt_overrun} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b required 0", {object_color, station_color,
               object_valid, station_valid, evt_valid, evt_channel, evt_color, evt_overrun});
    end
    repeat (2) to_tick();
    checks++;
    if (object_color !== 2'd0) begin
      errors++;
      $display("FAIL mid_restart_early: color=%0d required 0", object_color);
    end
    to_tick();
    checks++;
    if (object_color !== 2'd1) begin
      errors++;
      $display("FAIL mid_restart_accept: color=%0d required 1", object_color);
    end
    sb.push_back('{ch: 1'b0, col: 2'd1});
    handle_event(4, w);
  endtask

  task automatic test_hold();
    int w;
    int drop_at;
`ifdef COLOR_STABILIZER_HOLD_EN
    drop_at = HC;
`else
    drop_at = CC;
`endif
    do_reset();
    obj_in = 2'd1;
    repeat (3) to_tick();
    sb.push_back('{ch: 1'b0, col: 2'd1});
    handle_event(4, w);
    obj_in = 2'd0;
    for (int k = 1; k <= drop_at; k++) begin
      to_tick();
      checks++;
      if (k < drop_at && object_color !== 2'd1) begin
        errors++;
        $display("FAIL hold_keep: sample %0d color=%0d required 1", k, object_color);
      end else if (k == drop_at && object_color !== 2'd0) begin
        errors++;
        $display("FAIL hold_drop: sample %0d color=%0d required 0", k, object_color);
      end
    end
    checks++;
    if (object_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid_sticky: got %b required 1", object_valid);
    end
    sb.push_back('{ch: 1'b0, col: 2'd0});
    handle_event(4, w);
  endtask

  initial begin
    rst     = 1'b1;
    evt_ack = 1'b0;
    obj_in  = 2'd0;
    sta_in  = 2'd0;
    test_reset();
    test_basic();
    test_flicker();
    test_simultaneous();
    test_overrun();
    test_reset_mid();
    test_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d events never seen", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
